div_pip_sched: RTL and testbench

//  Round-robin scheduler that shares one pipelined non-restoring fractional divider among
//  NUM_REQ requesters in the WFQ datapath (per-flow finish-tag ratio computation).
//  The divider has no valid, tag or stall, so this block carries a valid/ID/error tag line

---
 rtl/div_pip_sched.sv | 174 +++++++++++++++++
 tb/tb_div_pip_sched.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_pip_sched.sv
// Round-robin scheduler feeding one shared pipelined fractional divider.
// Carries a {valid,id,err} tag line alongside the divider and routes each
// quotient back to its owner in grant order.
module div_pip_sched #(
  parameter int unsigned N       = 16,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned DIV_LAT = 17
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*N-1:0] req_dividend,
  input  logic [NUM_REQ*N-1:0] req_divisor,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 hold,
  output logic [N-1:0]         div_dividend,
  output logic [N-1:0]         div_divisor,
  input  logic [N-1:0]         div_quotient,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [N-1:0]         rsp_quotient,
  output logic                 rsp_err,
  output logic                 busy
);

  localparam int unsigned CNT_W = $clog2(DIV_LAT + 3);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic            err;
  } tag_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  tag_t              tag_q [DIV_LAT+1];
  tag_t              tag_d [DIV_LAT+1];
  logic [N-1:0]      div_dividend_q, div_dividend_d;
  logic [N-1:0]      div_divisor_q, div_divisor_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [N-1:0]      rsp_quotient_q, rsp_quotient_d;
  logic              rsp_err_q, rsp_err_d;

  logic              xfer_c;
  logic [ID_W-1:0]   gnt_idx_c;
  logic [NUM_REQ-1:0] grant_c;
  logic [N-1:0]      sel_dividend_c, sel_divisor_c;
  logic              sel_err_c;

  // Round-robin search from the pointer; hold suppresses every grant
  always_comb begin
    logic [ID_W-1:0] idx;
    grant_c   = '0;
    gnt_idx_c = '0;
    xfer_c    = 1'b0;
    idx       = '0;
    if (!hold) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        idx = ID_W'((32'(ptr_q) + k) % NUM_REQ);
        if (!xfer_c && req_valid[idx]) begin
          xfer_c    = 1'b1;
          gnt_idx_c = idx;
        end
      end
    end
    if (xfer_c) grant_c[gnt_idx_c] = 1'b1;
  end

  assign req_ready = grant_c;

  // Operand mux for the granted requester and legality check
  always_comb begin
    sel_dividend_c = '0;
    sel_divisor_c  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx_c == ID_W'(i)) begin
        sel_dividend_c = req_dividend[i*N +: N];
        sel_divisor_c  = req_divisor[i*N +: N];
      end
    end
    // dividend >= divisor also covers divisor == 0
    sel_err_c = (sel_dividend_c >= sel_divisor_c);
  end

  // Next-state for datapath, tag line, counter, pointer and FSM
  always_comb begin
    ptr_d          = ptr_q;
    cnt_d          = cnt_q;
    state_d        = state_q;
    div_dividend_d = div_dividend_q;
    div_divisor_d  = div_divisor_q;
    rsp_valid_d    = 1'b0;
    rsp_id_d       = rsp_id_q;
    rsp_quotient_d = rsp_quotient_q;
    rsp_err_d      = rsp_err_q;
    for (int unsigned k = 0; k <= DIV_LAT; k++) tag_d[k] = '0;

    if (xfer_c) begin
      div_dividend_d = sel_dividend_c;
      div_divisor_d  = sel_divisor_c;
      ptr_d = (gnt_idx_c == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx_c + ID_W'(1);
      tag_d[0] = '{valid: 1'b1, id: gnt_idx_c, err: sel_err_c};
    end
    for (int unsigned k = 1; k <= DIV_LAT; k++) tag_d[k] = tag_q[k-1];

    // Last tag stage lines up with the divider output
    if (tag_q[DIV_LAT].valid) begin
      rsp_valid_d    = 1'b1;
      rsp_id_d       = tag_q[DIV_LAT].id;
      rsp_err_d      = tag_q[DIV_LAT].err;
      rsp_quotient_d = tag_q[DIV_LAT].err ? {N{1'b1}} : div_quotient;
    end

    case ({xfer_c, rsp_valid_q})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    case (state_q)
      IDLE: if (xfer_c) state_d = RUN;
      RUN: begin
        if (!xfer_c && cnt_d == '0)    state_d = IDLE;
        else if (hold && cnt_q != '0)  state_d = DRAIN;
      end
      DRAIN: begin
        if (!xfer_c && cnt_d == '0)    state_d = IDLE;
        else if (!hold && xfer_c)      state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      ptr_q          <= '0;
      cnt_q          <= '0;
      div_dividend_q <= '0;
      div_divisor_q  <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= '0;
      rsp_quotient_q <= '0;
      rsp_err_q      <= 1'b0;
      for (int unsigned k = 0; k <= DIV_LAT; k++) tag_q[k] <= '0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      cnt_q          <= cnt_d;
      div_dividend_q <= div_dividend_d;
      div_divisor_q  <= div_divisor_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_id_q       <= rsp_id_d;
      rsp_quotient_q <= rsp_quotient_d;
      rsp_err_q      <= rsp_err_d;
      for (int unsigned k = 0; k <= DIV_LAT; k++) tag_q[k] <= tag_d[k];
    end
  end

  assign div_dividend = div_dividend_q;
  assign div_divisor  = div_divisor_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_quotient = rsp_quotient_q;
  assign rsp_err      = rsp_err_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_div_pip_sched.sv
// Directed bench for div_pip_sched with a behavioural 17-stage divider stub.
module tb_div_pip_sched;

  localparam int unsigned N = 16;
  localparam int unsigned NR = 4;
  localparam int unsigned IW = 2;
  localparam int unsigned LAT = 17;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR*N-1:0] req_dividend;
  logic [NR*N-1:0] req_divisor;
  logic [NR-1:0]   req_ready;
  logic            hold;
  logic [N-1:0]    div_dividend, div_divisor, div_quotient;
  logic            rsp_valid;
  logic [IW-1:0]   rsp_id;
  logic [N-1:0]    rsp_quotient;
  logic            rsp_err;
  logic            busy;

  int checks = 0;
  int errors = 0;

  div_pip_sched #(.N(N), .NUM_REQ(NR), .ID_W(IW), .DIV_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_dividend(req_dividend),
    .req_divisor(req_divisor), .req_ready(req_ready), .hold(hold),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_quotient(rsp_quotient), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Divider stub: floor(a*2^N/b), LAT cycles from div_* to div_quotient
  function automatic logic [N-1:0] qf(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [2*N-1:0] num;
    logic [2*N-1:0] q;
    if (b == '0) return '0;
    num = {a, {N{1'b0}}};
    q = num / {{N{1'b0}}, b};
    return q[N-1:0];
  endfunction

  logic [N-1:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= qf(div_dividend, div_divisor);
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign div_quotient = pipe[LAT-1];

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
    req_dividend[i*N +: N] = a;
    req_divisor[i*N +: N]  = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    hold = 1'b0;
    repeat (3) next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; hold = 1'b0;
    req_dividend = '0; req_divisor = '0;
    repeat (3) next_cycle();
    #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_err, busy} !== 5'b0 || rsp_quotient !== 16'h0) begin
      errors++;
      $display("FAIL reset_rsp got v=%b id=%0d q=%h e=%b busy=%b exp all zero",
               rsp_valid, rsp_id, rsp_quotient, rsp_err, busy);
    end
    checks++;
    if (div_dividend !== 16'h0 || div_divisor !== 16'h0) begin
      errors++;
      $display("FAIL reset_div got %h/%h exp 0000/0000", div_dividend, div_divisor);
    end
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_single();
    set_op(0, 16'h4000, 16'h8000);
    for (int c = 0; c <= 20; c++) begin
      req_valid = (c == 0) ? 4'b0001 : 4'b0000;
      #1;
      if (c == 0) begin
        checks++;
        if (req_ready !== 4'b0001) begin
          errors++; $display("FAIL t1_ready got %b exp 0001", req_ready);
        end
      end
      if (c == 1) begin
        checks++;
        if (div_dividend !== 16'h4000 || div_divisor !== 16'h8000) begin
          errors++; $display("FAIL t1_issue got %h/%h exp 4000/8000", div_dividend, div_divisor);
        end
      end
      if (c == 18) begin
        checks++;
        if (rsp_valid !== 1'b0) begin
          errors++; $display("FAIL t1_early got %b exp 0", rsp_valid);
        end
      end
      if (c == 19) begin
        checks++;
        if ({rsp_valid, rsp_id, rsp_err} !== 4'b1000 || rsp_quotient !== 16'h8000 || busy !== 1'b1) begin
          errors++;
          $display("FAIL t1_rsp got v=%b id=%0d q=%h e=%b busy=%b exp v=1 id=0 q=8000 e=0 busy=1",
                   rsp_valid, rsp_id, rsp_quotient, rsp_err, busy);
        end
      end
      if (c == 20) begin
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_quotient !== 16'h8000) begin
          errors++;
          $display("FAIL t1_after got v=%b busy=%b q=%h exp v=0 busy=0 q=8000", rsp_valid, busy, rsp_quotient);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_trunc();
    set_op(2, 16'h1000, 16'h3000);
    for (int c = 0; c <= 19; c++) begin
      req_valid = (c == 0) ? 4'b0100 : 4'b0000;
      #1;
      if (c == 0) begin
        checks++;
        if (req_ready !== 4'b0100) begin
          errors++; $display("FAIL t2_ready got %b exp 0100", req_ready);
        end
      end
      if (c == 19) begin
        checks++;
        if ({rsp_valid, rsp_id, rsp_err} !== 4'b1100 || rsp_quotient !== 16'h5555) begin
          errors++;
          $display("FAIL t2_rsp got v=%b id=%0d q=%h e=%b exp v=1 id=2 q=5555 e=0",
                   rsp_valid, rsp_id, rsp_quotient, rsp_err);
        end
      end
      next_cycle();
    end
    repeat (3) next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [NR-1:0] pend;
    logic [N-1:0] exp_q [4] = '{16'h2000, 16'h4000, 16'h6000, 16'h8000};
    do_reset();
    for (int i = 0; i < 4; i++) set_op(i, N'((i + 1) * 32'h1000), 16'h8000);
    pend = 4'b1111;
    for (int c = 0; c <= 23; c++) begin
      req_valid = pend;
      #1;
      if (c < 4) begin
        checks++;
        if (req_ready !== NR'(1 << c)) begin
          errors++; $display("FAIL t3_grant%0d got %b exp %b", c, req_ready, NR'(1 << c));
        end
        pend[c] = 1'b0;
      end
      if (c >= 19 && c <= 22) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== IW'(c - 19) || rsp_err !== 1'b0 || rsp_quotient !== exp_q[c-19]) begin
          errors++;
          $display("FAIL t3_rsp%0d got v=%b id=%0d q=%h e=%b exp v=1 id=%0d q=%h e=0",
                   c - 19, rsp_valid, rsp_id, rsp_quotient, rsp_err, c - 19, exp_q[c-19]);
        end
      end
      if (c == 23) begin
        checks++;
        if (rsp_valid !== 1'b0) begin
          errors++; $display("FAIL t3_end got %b exp 0", rsp_valid);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_illegal();
    for (int c = 0; c <= 21; c++) begin
      if (c == 0) begin set_op(1, 16'h1234, 16'h0000); req_valid = 4'b0010; end
      else if (c == 1) begin set_op(1, 16'h9000, 16'h8000); req_valid = 4'b0010; end
      else req_valid = 4'b0000;
      #1;
      if (c < 2) begin
        checks++;
        if (req_ready !== 4'b0010) begin
          errors++; $display("FAIL t4_grant%0d got %b exp 0010", c, req_ready);
        end
      end
      if (c == 19 || c == 20) begin
        checks++;
        if ({rsp_valid, rsp_id, rsp_err} !== 4'b1011 || rsp_quotient !== 16'hFFFF) begin
          errors++;
          $display("FAIL t4_rsp%0d got v=%b id=%0d q=%h e=%b exp v=1 id=1 q=ffff e=1",
                   c - 19, rsp_valid, rsp_id, rsp_quotient, rsp_err);
        end
      end
      if (c == 21) begin
        checks++;
        if (rsp_valid !== 1'b0) begin
          errors++; $display("FAIL t4_end got %b exp 0", rsp_valid);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_hold();
    int exp_id [7] = '{2, 3, 0, 1, 2, 3, 0};
    int exp_cyc [7] = '{19, 20, 21, 22, 23, 24, 55};
    int nresp = 0;
    for (int i = 0; i < 4; i++) set_op(i, N'((i + 1) * 32'h1000), 16'h8000);
    for (int c = 0; c <= 60; c++) begin
      hold = (c >= 6 && c <= 35);
      req_valid = (c <= 36) ? 4'b1111 : 4'b0000;
      #1;
      if (c < 6 || c == 36) begin
        checks++;
        if (req_ready !== NR'(1 << exp_id[(c == 36) ? 6 : c])) begin
          errors++; $display("FAIL t5_grant_c%0d got %b exp %b", c, req_ready,
                             NR'(1 << exp_id[(c == 36) ? 6 : c]));
        end
      end else if (c <= 35) begin
        checks++;
        if (req_ready !== 4'b0000) begin
          errors++; $display("FAIL t5_hold_c%0d got %b exp 0000", c, req_ready);
        end
      end
      if (rsp_valid === 1'b1) begin
        checks++;
        if (nresp >= 7) begin
          errors++; $display("FAIL t5_extra_rsp c%0d got id=%0d exp none", c, rsp_id);
        end else if (c != exp_cyc[nresp] || rsp_id !== IW'(exp_id[nresp]) || rsp_err !== 1'b0 ||
                     rsp_quotient !== N'((exp_id[nresp] + 1) * 32'h2000)) begin
          errors++;
          $display("FAIL t5_rsp%0d got c=%0d id=%0d q=%h e=%b exp c=%0d id=%0d q=%h e=0",
                   nresp, c, rsp_id, rsp_quotient, rsp_err, exp_cyc[nresp], exp_id[nresp],
                   N'((exp_id[nresp] + 1) * 32'h2000));
        end
        nresp++;
      end
      if (c == 6 || c == 24 || c == 25 || c == 56) begin
        checks++;
        if (busy !== ((c == 6 || c == 24) ? 1'b1 : 1'b0)) begin
          errors++; $display("FAIL t5_busy_c%0d got %b exp %b", c, busy, (c == 6 || c == 24));
        end
      end
      next_cycle();
    end
    hold = 1'b0;
    checks++;
    if (nresp != 7) begin
      errors++; $display("FAIL t5_count got %0d exp 7", nresp);
    end
  endtask

  task automatic test_reset_mid();
    logic [NR-1:0] pend = 4'b0111;
    int exp_g [3] = '{1, 2, 0};
    int nresp = 0;
    for (int c = 0; c <= 40; c++) begin
      rst = (c == 7);
      if (c < 3) req_valid = pend;
      else if (c == 8) req_valid = 4'b1111;
      else req_valid = 4'b0000;
      #1;
      if (c < 3) begin
        checks++;
        if (req_ready !== NR'(1 << exp_g[c])) begin
          errors++; $display("FAIL t6_grant%0d got %b exp %b", c, req_ready, NR'(1 << exp_g[c]));
        end
        pend[exp_g[c]] = 1'b0;
      end
      if (c == 8) begin
        checks++;
        if (busy !== 1'b0 || req_ready !== 4'b0001) begin
          errors++; $display("FAIL t6_post_rst got busy=%b ready=%b exp busy=0 ready=0001", busy, req_ready);
        end
      end
      if (rsp_valid === 1'b1) begin
        nresp++;
        checks++;
        if (c != 27 || rsp_id !== 2'd0 || rsp_quotient !== 16'h2000) begin
          errors++;
          $display("FAIL t6_rsp got c=%0d id=%0d q=%h exp c=27 id=0 q=2000", c, rsp_id, rsp_quotient);
        end
      end
      next_cycle();
    end
    rst = 1'b0;
    checks++;
    if (nresp != 1) begin
      errors++; $display("FAIL t6_count got %0d exp 1", nresp);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_trunc();
    test_back_to_back();
    test_illegal();
    test_hold();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
